// File: rtl/byte_burst_arbiter.sv
// rtl/byte_burst_arbiter.sv - two-producer byte arbiter with burst limit and registered output
// byte_selector is the shared datapath; the arbiter drives its select and registers its result.

module byte_selector (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       sel,
   output logic [7:0] y
);
   assign y = sel ? b : a;
endmodule

module byte_burst_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             out_src,
   output logic             sel
);
   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   logic             last;
   logic [3:0]       burst_cnt;
   logic             load_en;
   logic             grant_vld;
   logic             grant;
   logic [WIDTH-1:0] sel_data;

   byte_selector u_byte_selector (
      .a   (in0_data),
      .b   (in1_data),
      .sel (sel),
      .y   (sel_data)
   );

   // grant defaults to last so sel keeps pointing at the previous owner when idle
   always_comb begin
      load_en   = !out_valid || out_ready;
      grant_vld = 1'b0;
      grant     = last;
      if (load_en) begin
         if (in0_valid && in1_valid) begin
            grant_vld = 1'b1;
            grant     = (burst_cnt < MAX_CNT) ? last : !last;
         end else if (in0_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b0;
         end else if (in1_valid) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
         end
      end
      sel       = grant;
      in0_ready = grant_vld && !grant;
      in1_ready = grant_vld && grant;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         last      <= 1'b0;
         burst_cnt <= 4'd0;
      end else if (load_en) begin
         if (grant_vld) begin
            out_data  <= sel_data;
            out_src   <= grant;
            out_valid <= 1'b1;
            if (grant == last && burst_cnt != 4'd0) begin
               if (burst_cnt < MAX_CNT)
                  burst_cnt <= burst_cnt + 4'd1;
            end else begin
               burst_cnt <= 4'd1;
               last      <= grant;
            end
         end else begin
            // an idle slot ends any burst in progress
            out_valid <= 1'b0;
            burst_cnt <= 4'd0;
         end
      end
   end
endmodule
